// File: rtl/point_read_arbiter_if.sv
// rtl/point_read_arbiter_if.sv - requester, response and external point-source signals of the point read arbiter
interface point_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 19
);
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ*ID_W-1:0] i_req_id;
    logic [NUM_REQ-1:0]      o_rsp_valid;
    logic [NUM_REQ-1:0]      i_rsp_ready;
    logic                    o_rsp_err;
    logic [15:0]             o_rsp_h;
    logic [15:0]             o_rsp_v;
    logic [15:0]             o_rsp_r;
    logic                    EXT_readReady;
    logic                    EXT_readValid;
    logic [ID_W-1:0]         EXT_readID;
    logic [15:0]             EXT_pointAngleH;
    logic [15:0]             EXT_pointAngleV;
    logic [15:0]             EXT_pointRadius;
    logic                    o_busy;
    logic                    o_timeout;
    logic [15:0]             o_xfer_count;

    // Arbiter side.
    modport master (
        input  i_req_valid, i_req_id, i_rsp_ready,
        input  EXT_readValid, EXT_pointAngleH, EXT_pointAngleV, EXT_pointRadius,
        output o_rsp_valid, o_rsp_err, o_rsp_h, o_rsp_v, o_rsp_r,
        output EXT_readReady, EXT_readID, o_busy, o_timeout, o_xfer_count
    );

    // Requesters plus point source.
    modport slave (
        output i_req_valid, i_req_id, i_rsp_ready,
        output EXT_readValid, EXT_pointAngleH, EXT_pointAngleV, EXT_pointRadius,
        input  o_rsp_valid, o_rsp_err, o_rsp_h, o_rsp_v, o_rsp_r,
        input  EXT_readReady, EXT_readID, o_busy, o_timeout, o_xfer_count
    );
endinterface

// File: rtl/point_read_arbiter.sv
// rtl/point_read_arbiter.sv - round-robin sharing of one external point read port between NUM_REQ readers
module point_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 19,
    parameter int TIMEOUT = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    point_read_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [9:0]         wd_q, wd_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               ready_q, ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [15:0]        rsp_h_q, rsp_h_d;
    logic [15:0]        rsp_v_q, rsp_v_d;
    logic [15:0]        rsp_r_q, rsp_r_d;
    logic               timeout_q, timeout_d;
    logic [15:0]        count_q, count_d;

    logic               found;
    logic [IDX_W-1:0]   gsel;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] grant_onehot;

    // Round-robin search starting just after the last lane served.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.i_req_valid[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wd_d        = wd_q;
        id_d        = id_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_h_d     = rsp_h_q;
        rsp_v_d     = rsp_v_q;
        rsp_r_d     = rsp_r_q;
        timeout_d   = 1'b0;
        count_d     = count_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = gsel;
                    id_d    = bus.i_req_id[int'(gsel)*ID_W +: ID_W];
                    ready_d = 1'b1;
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A valid on the final watchdog cycle still completes normally.
                if (bus.EXT_readValid) begin
                    rsp_h_d     = bus.EXT_pointAngleH;
                    rsp_v_d     = bus.EXT_pointAngleV;
                    rsp_r_d     = bus.EXT_pointRadius;
                    ready_d     = 1'b0;
                    rsp_valid_d = grant_onehot;
                    rsp_err_d   = 1'b0;
                    count_d     = count_q + 16'd1;
                    state_d     = RESP;
                end else if (wd_q == 10'(TIMEOUT - 1)) begin
                    ready_d     = 1'b0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = grant_onehot;
                    rsp_err_d   = 1'b1;
                    rsp_h_d     = '0;
                    rsp_v_d     = '0;
                    rsp_r_d     = '0;
                    state_d     = RESP;
                end else begin
                    wd_d = wd_q + 10'd1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    rsp_err_d   = 1'b0;
                    last_d      = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            wd_q        <= '0;
            id_q        <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_h_q     <= '0;
            rsp_v_q     <= '0;
            rsp_r_q     <= '0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            id_q        <= id_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_h_q     <= rsp_h_d;
            rsp_v_q     <= rsp_v_d;
            rsp_r_q     <= rsp_r_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
        end
    end

    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_err     = rsp_err_q;
    assign bus.o_rsp_h       = rsp_h_q;
    assign bus.o_rsp_v       = rsp_v_q;
    assign bus.o_rsp_r       = rsp_r_q;
    assign bus.EXT_readReady = ready_q;
    assign bus.EXT_readID    = id_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_timeout     = timeout_q;
    assign bus.o_xfer_count  = count_q;
endmodule

// File: tb/tb_point_read_arbiter.sv
// tb/tb_point_read_arbiter.sv - directed self-checking bench for point_read_arbiter
module tb_point_read_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 19;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerr;

    point_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    point_read_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ids(input logic [ID_W-1:0] id0, input logic [ID_W-1:0] id1);
        bus.i_req_id = {id1, id0};
    endtask

    task automatic set_ext(input logic v, input logic [15:0] h, input logic [15:0] a, input logic [15:0] r);
        bus.EXT_readValid   = v;
        bus.EXT_pointAngleH = h;
        bus.EXT_pointAngleV = a;
        bus.EXT_pointRadius = r;
    endtask

    initial begin
        int ready_cycles;
        int to_pulses;
        logic [ID_W-1:0] exp_id [4];
        logic [1:0]      exp_g  [4];
        nchecks = 0;
        nerr    = 0;
        exp_id  = '{19'd10, 19'd20, 19'd10, 19'd20};
        exp_g   = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n           = 1'b0;
        bus.i_req_valid = '0;
        bus.i_rsp_ready = '0;
        set_ids(19'd0, 19'd0);
        set_ext(1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        chk("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("reset_ready", 32'(bus.EXT_readReady), 32'h0);
        chk("reset_busy", 32'(bus.o_busy), 32'h0);
        chk("reset_count", 32'(bus.o_xfer_count), 32'h0);
        rst_n = 1'b1;

        // Single read from lane 0, source answers two cycles after ready.
        set_ids(19'd5, 19'd0);
        bus.i_req_valid = 2'b01;
        tick();
        chk("t1_ready", 32'(bus.EXT_readReady), 32'h1);
        chk("t1_id", 32'(bus.EXT_readID), 32'd5);
        chk("t1_busy", 32'(bus.o_busy), 32'h1);
        tick();
        chk("t1_still_ready", 32'(bus.EXT_readReady), 32'h1);
        set_ext(1'b1, 16'h1111, 16'h2222, 16'h3333);
        tick();
        set_ext(1'b0, 16'h0, 16'h0, 16'h0);
        chk("t1_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
        chk("t1_h", 32'(bus.o_rsp_h), 32'h1111);
        chk("t1_v", 32'(bus.o_rsp_v), 32'h2222);
        chk("t1_r", 32'(bus.o_rsp_r), 32'h3333);
        chk("t1_err", 32'(bus.o_rsp_err), 32'h0);
        chk("t1_count", 32'(bus.o_xfer_count), 32'd1);
        chk("t1_ready_low", 32'(bus.EXT_readReady), 32'h0);
        bus.i_rsp_ready = 2'b01;
        bus.i_req_valid = 2'b00;
        tick();
        chk("t1_rsp_done", 32'(bus.o_rsp_valid), 32'h0);
        chk("t1_idle", 32'(bus.o_busy), 32'h0);
        bus.i_rsp_ready = 2'b00;

        // Lane 1 read with a silent source: watchdog abort.
        set_ids(19'd0, 19'd7);
        bus.i_req_valid = 2'b10;
        tick();
        bus.i_req_valid = 2'b00;
        ready_cycles = 0;
        to_pulses    = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.EXT_readReady) ready_cycles++;
            if (bus.o_timeout) to_pulses++;
            if (bus.o_rsp_valid != 2'b00) break;
            tick();
        end
        chk("to_ready_cycles", 32'(ready_cycles), 32'd8);
        chk("to_pulse", 32'(to_pulses), 32'd1);
        chk("to_rsp_valid", 32'(bus.o_rsp_valid), 32'h2);
        chk("to_err", 32'(bus.o_rsp_err), 32'h1);
        chk("to_h", 32'(bus.o_rsp_h), 32'h0);
        chk("to_r", 32'(bus.o_rsp_r), 32'h0);
        chk("to_count", 32'(bus.o_xfer_count), 32'd1);
        tick();
        chk("to_pulse_end", 32'(bus.o_timeout), 32'h0);
        chk("to_rsp_hold", 32'(bus.o_rsp_valid), 32'h2);
        bus.i_rsp_ready = 2'b10;
        tick();
        chk("to_rsp_done", 32'(bus.o_rsp_valid), 32'h0);
        chk("to_err_clr", 32'(bus.o_rsp_err), 32'h0);

        // Both lanes continuously, source always valid, ready tied high.
        set_ids(19'd10, 19'd20);
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        set_ext(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_id", 32'(bus.EXT_readID), 32'(exp_id[k]));
            chk("rr_ready", 32'(bus.EXT_readReady), 32'h1);
            tick();
            chk("rr_grant", 32'(bus.o_rsp_valid), 32'(exp_g[k]));
            chk("rr_h", 32'(bus.o_rsp_h), 32'hAAAA);
            tick();
            chk("rr_release", 32'(bus.o_rsp_valid), 32'h0);
        end
        chk("rr_count", 32'(bus.o_xfer_count), 32'd5);
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b00;
        set_ext(1'b0, 16'h0, 16'h0, 16'h0);

        // Response backpressure on lane 0 while lane 1 waits.
        bus.i_req_valid = 2'b01;
        tick();
        chk("bp_id", 32'(bus.EXT_readID), 32'd10);
        set_ext(1'b1, 16'h1234, 16'h5678, 16'h9ABC);
        tick();
        set_ext(1'b0, 16'h0, 16'h0, 16'h0);
        bus.i_req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(bus.o_rsp_valid), 32'h1);
            chk("bp_h", 32'(bus.o_rsp_h), 32'h1234);
            chk("bp_r", 32'(bus.o_rsp_r), 32'h9ABC);
            chk("bp_ready_low", 32'(bus.EXT_readReady), 32'h0);
        end
        bus.i_rsp_ready = 2'b01;
        tick();
        bus.i_rsp_ready = 2'b00;
        bus.i_req_valid = 2'b10;
        chk("bp_accept", 32'(bus.o_rsp_valid), 32'h0);
        tick();
        chk("bp_lane1_ready", 32'(bus.EXT_readReady), 32'h1);
        chk("bp_lane1_id", 32'(bus.EXT_readID), 32'd20);

        // Asynchronous reset between clock edges during ISSUE.
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(bus.EXT_readReady), 32'h0);
        chk("ar_busy", 32'(bus.o_busy), 32'h0);
        chk("ar_id", 32'(bus.EXT_readID), 32'h0);
        chk("ar_count", 32'(bus.o_xfer_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_lane1_ready", 32'(bus.EXT_readReady), 32'h1);
        chk("ar_lane1_id", 32'(bus.EXT_readID), 32'd20);

        // Valid arrives on the final watchdog cycle: normal completion.
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            tick();
            chk("edge_ready", 32'(bus.EXT_readReady), 32'h1);
        end
        set_ext(1'b1, 16'h0ABC, 16'h0DEF, 16'h0123);
        tick();
        set_ext(1'b0, 16'h0, 16'h0, 16'h0);
        chk("edge_valid", 32'(bus.o_rsp_valid), 32'h2);
        chk("edge_err", 32'(bus.o_rsp_err), 32'h0);
        chk("edge_timeout", 32'(bus.o_timeout), 32'h0);
        chk("edge_h", 32'(bus.o_rsp_h), 32'h0ABC);
        chk("edge_count", 32'(bus.o_xfer_count), 32'd1);
        tick();
        chk("edge_no_late_pulse", 32'(bus.o_timeout), 32'h0);
        bus.i_rsp_ready = 2'b10;
        bus.i_req_valid = 2'b00;
        tick();
        chk("edge_done", 32'(bus.o_rsp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
